// File: rtl/temp_disp_pkg.sv
// Shared types and constants for the temperature display sequencer and scan.
package temp_disp_pkg;

  localparam int N_POS = 5;
  localparam int TC_W  = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACC,
    S_UPDATE
  } smp_state_t;

  typedef logic [2:0] pos_idx_t;

endpackage

// File: rtl/temp_disp_ctl_if.sv
// Sensor read bus: request pulse out, one-cycle ack with signed reading back.
interface temp_disp_ctl_if;
  import temp_disp_pkg::*;

  logic                   rd_req;
  logic                   rd_ack;
  logic signed [TC_W-1:0] rd_data;

  modport master (output rd_req, input rd_ack, input rd_data);
  modport slave  (input rd_req, output rd_ack, output rd_data);

endinterface

// File: rtl/disp_scan.sv
// Five-position seven-segment scan (sign + 4 digits) with leading-zero blanking.
// Outputs registered: one cycle behind the BCD inputs; no backpressure.
module disp_scan
  import temp_disp_pkg::*;
#(
  parameter int SCAN_CYCLES = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_force_minus,
  input  logic [3:0]       i_thousands,
  input  logic [3:0]       i_hundreds,
  input  logic [3:0]       i_tens,
  input  logic [3:0]       i_ones,
  input  logic             i_sign,
  output logic [N_POS-1:0] o_an,
  output logic [3:0]       o_digit,
  output logic             o_seg_blank,
  output logic             o_seg_minus
);

  localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [SCW-1:0]   r_cnt;
  pos_idx_t         r_pos;
  logic             w_adv;
  logic [N_POS-1:0] w_an;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic             w_minus;

  logic [N_POS-1:0] r_an;
  logic [3:0]       r_digit;
  logic             r_blank;
  logic             r_minus;

  assign w_adv = (r_cnt == SCW'(SCAN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_pos <= '0;
    end else if (w_adv) begin
      r_cnt <= '0;
      r_pos <= (r_pos == pos_idx_t'(N_POS - 1)) ? '0 : r_pos + pos_idx_t'(1);
    end else begin
      r_cnt <= r_cnt + SCW'(1);
    end
  end

  always_comb begin
    w_an    = ~(N_POS'(1) << r_pos);
    w_digit = 4'd0;
    w_blank = 1'b0;
    w_minus = 1'b0;
    case (r_pos)
      pos_idx_t'(0): w_digit = i_ones;
      pos_idx_t'(1): w_digit = i_tens;
      pos_idx_t'(2): begin
        w_digit = i_hundreds;
        w_blank = (i_thousands == 4'd0) && (i_hundreds == 4'd0);
      end
      pos_idx_t'(3): begin
        w_digit = i_thousands;
        w_blank = (i_thousands == 4'd0);
      end
      default: begin
        w_blank = ~i_sign;
        w_minus = i_sign;
      end
    endcase
    // Error display overrides every position with a dash.
    if (i_force_minus) begin
      w_blank = 1'b0;
      w_minus = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an    <= {{(N_POS-1){1'b1}}, 1'b0};
      r_digit <= i_ones;
      r_blank <= 1'b0;
      r_minus <= 1'b0;
    end else begin
      r_an    <= w_an;
      r_digit <= w_digit;
      r_blank <= w_blank;
      r_minus <= w_minus;
    end
  end

  assign o_an        = r_an;
  assign o_digit     = r_digit;
  assign o_seg_blank = r_blank;
  assign o_seg_minus = r_minus;

endmodule

// File: rtl/temp_disp_ctl.sv
// Sample sequencer: periodic bursts of 2^AVG_LOG2 sensor reads, averaged into tc; drives disp_scan.
// Define TEMP_DISP_ERR_EN to show "-----" on the display while the sticky timeout flag is set.
module temp_disp_ctl
  import temp_disp_pkg::*;
#(
  parameter int SAMPLE_CYCLES  = 1_000_000,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int SCAN_CYCLES    = 100_000
) (
  input  logic                   clk,
  input  logic                   rst,
  temp_disp_ctl_if.master        sns_if,
  input  logic                   i_cf_pulse,
  output logic signed [TC_W-1:0] o_tc,
  output logic                   o_c_f,
  output logic                   o_upd,
  output logic                   o_err,
  input  logic [3:0]             i_thousands,
  input  logic [3:0]             i_hundreds,
  input  logic [3:0]             i_tens,
  input  logic [3:0]             i_ones,
  input  logic                   i_sign,
  output logic [N_POS-1:0]       o_an,
  output logic [3:0]             o_digit,
  output logic                   o_seg_blank,
  output logic                   o_seg_minus
);

  localparam int SMP_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ACC_W = TC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  smp_state_t              r_state;
  smp_state_t              w_state_nxt;
  logic [SMP_W-1:0]        r_smp_cnt;
  logic [TO_W-1:0]         r_to_cnt;
  logic signed [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [TC_W-1:0]  r_rd_dat;
  logic signed [TC_W-1:0]  r_tc;
  logic                    r_c_f;
  logic                    r_err;

  logic                    w_tick;
  logic [TO_W-1:0]         w_to_nxt;
  logic                    w_to_hit;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_cnt_full;
  logic signed [ACC_W-1:0] w_sum_nxt;
  logic signed [ACC_W-1:0] w_avg;
  logic                    w_rd_req;
  logic                    w_upd;
  logic                    w_timeout;
  logic                    w_force_minus;

  assign w_tick     = (r_smp_cnt == SMP_W'(SAMPLE_CYCLES - 1));
  assign w_to_nxt   = r_to_cnt + TO_W'(1);
  assign w_to_hit   = (w_to_nxt == TO_W'(TIMEOUT_CYCLES));
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_cnt_full = (w_cnt_nxt == CNT_W'(1 << AVG_LOG2));
  assign w_sum_nxt  = r_sum + ACC_W'(r_rd_dat);
  assign w_avg      = r_sum >>> AVG_LOG2;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_req    = 1'b0;
    w_upd       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: if (w_tick) w_state_nxt = S_REQ;
      S_REQ: begin
        w_rd_req    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // An ack landing on the timeout cycle still wins.
        if (sns_if.rd_ack) begin
          w_state_nxt = S_ACC;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ACC:    w_state_nxt = w_cnt_full ? S_UPDATE : S_REQ;
      S_UPDATE: begin
        w_upd       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_smp_cnt <= '0;
      r_to_cnt  <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_rd_dat  <= '0;
      r_tc      <= '0;
      r_c_f     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_smp_cnt <= w_tick ? '0 : r_smp_cnt + SMP_W'(1);
      r_c_f     <= r_c_f ^ i_cf_pulse;
      r_to_cnt  <= (r_state == S_WAIT) ? w_to_nxt : '0;
      if (r_state == S_WAIT && sns_if.rd_ack) r_rd_dat <= sns_if.rd_data;
      if (w_timeout) begin
        r_err <= 1'b1;
        r_sum <= '0;
        r_cnt <= '0;
      end
      if (r_state == S_ACC) begin
        r_sum <= w_sum_nxt;
        r_cnt <= w_cnt_nxt;
      end
      if (r_state == S_UPDATE) begin
        r_tc  <= w_avg[TC_W-1:0];
        r_sum <= '0;
        r_cnt <= '0;
      end
    end
  end

`ifdef TEMP_DISP_ERR_EN
  assign w_force_minus = r_err;
`else
  assign w_force_minus = 1'b0;
`endif

  disp_scan #(.SCAN_CYCLES(SCAN_CYCLES)) u_scan (
    .clk           (clk),
    .rst           (rst),
    .i_force_minus (w_force_minus),
    .i_thousands   (i_thousands),
    .i_hundreds    (i_hundreds),
    .i_tens        (i_tens),
    .i_ones        (i_ones),
    .i_sign        (i_sign),
    .o_an          (o_an),
    .o_digit       (o_digit),
    .o_seg_blank   (o_seg_blank),
    .o_seg_minus   (o_seg_minus)
  );

  assign sns_if.rd_req = w_rd_req;
  assign o_tc          = r_tc;
  assign o_c_f         = r_c_f;
  assign o_upd         = w_upd;
  assign o_err         = r_err;

endmodule

// File: tb/tb_temp_disp_ctl.sv
// Scoreboard bench for temp_disp_ctl: burst averaging, timeout, C/F toggle, scan walk, mid-burst reset.
module tb_temp_disp_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               cf_pulse;
  logic               sign;
  logic [3:0]         th, hu, te, on;
  logic signed [12:0] tc;
  logic               c_f, upd, err, seg_blank, seg_minus;
  logic [4:0]         an;
  logic [3:0]         digit;

  temp_disp_ctl_if sif();

  temp_disp_ctl #(
    .SAMPLE_CYCLES(8), .AVG_LOG2(2), .TIMEOUT_CYCLES(15), .SCAN_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .sns_if(sif), .i_cf_pulse(cf_pulse),
    .o_tc(tc), .o_c_f(c_f), .o_upd(upd), .o_err(err),
    .i_thousands(th), .i_hundreds(hu), .i_tens(te), .i_ones(on), .i_sign(sign),
    .o_an(an), .o_digit(digit), .o_seg_blank(seg_blank), .o_seg_minus(seg_minus)
  );

  typedef struct {
    logic [4:0] an;
    logic [3:0] d;
    logic       b;
    logic       m;
  } scan_t;

  int    total = 0;
  int    bad   = 0;
  int    rd_q[$];
  int    exp_q[$];
  scan_t scan_q[$];
  scan_t se;
  int    req_cnt = 0, upd_cnt = 0, tc_done = 0, ack_cnt = 0, req_at_upd = 0;
  int    exp_tc;
  bit    scan_chk = 1'b0;
  logic [4:0] prev_an;
  int    dwell = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sensor model: ack 3 cycles after each request, while readings are queued.
  initial begin
    sif.rd_ack  = 1'b0;
    sif.rd_data = '0;
    forever begin
      @(negedge clk);
      if (sif.rd_req === 1'b1) begin
        repeat (3) @(posedge clk);
        #1;
        if (!rst && rd_q.size() > 0) begin
          sif.rd_data = 13'(rd_q.pop_front());
          sif.rd_ack  = 1'b1;
          ack_cnt++;
          @(posedge clk);
          #1;
          sif.rd_ack = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (sif.rd_req === 1'b1) req_cnt++;
  end

  // tc monitor: tc takes the new average the cycle after the upd pulse.
  initial forever begin
    @(negedge clk);
    if (upd === 1'b1) begin
      upd_cnt++;
      req_at_upd = req_cnt;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL upd_unexpected: got upd=1 expected no update");
      end else begin
        exp_tc = exp_q.pop_front();
        @(negedge clk);
        chk("tc_avg", int'(tc), exp_tc);
        tc_done++;
      end
    end
  end

  // Scan monitor: compares each new lit position and its dwell time.
  initial forever begin
    @(negedge clk);
    if (scan_chk) begin
      if (an !== prev_an) begin
        se = scan_q.pop_front();
        chk("scan_an",    int'(an),        int'(se.an));
        chk("scan_digit", int'(digit),     int'(se.d));
        chk("scan_blank", int'(seg_blank), int'(se.b));
        chk("scan_minus", int'(seg_minus), int'(se.m));
        chk("scan_dwell", dwell, 2);
        dwell   = 1;
        prev_an = an;
        if (scan_q.size() == 0) scan_chk = 1'b0;
      end else begin
        dwell++;
      end
    end
  end

  task automatic push_scan(logic [4:0] a, logic [3:0] d, logic b, logic m);
    scan_t s;
    s.an = a; s.d = d; s.b = b; s.m = m;
    scan_q.push_back(s);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (5) tick();
    rd_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_req(string nm);
    int n = 0;
    while (sif.rd_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(nm, int'(sif.rd_req), 1);
  endtask

  task automatic wait_tc(int target);
    int n = 0;
    while (tc_done < target && n < 400) begin
      tick();
      n++;
    end
    chk("burst_done", tc_done, target);
  endtask

  task automatic scan_walk(logic [3:0] t3, logic [3:0] t2, logic [3:0] t1, logic [3:0] t0, logic s);
    logic [4:0] last;
    int n = 0;
    th = t3; hu = t2; te = t1; on = t0; sign = s;
    tick();
    tick();
    last = an;
    forever begin
      tick();
      n++;
      if ((an == 5'b11110 && last != 5'b11110) || n > 40) break;
      last = an;
    end
    chk("scan_align", int'(an), 5'b11110);
    prev_an = an;
    dwell   = 0;
    push_scan(5'b11101, t1, 1'b0, 1'b0);
    push_scan(5'b11011, t2, (t3 == 4'd0 && t2 == 4'd0), 1'b0);
    push_scan(5'b10111, t3, (t3 == 4'd0), 1'b0);
    push_scan(5'b01111, 4'd0, ~s, s);
    push_scan(5'b11110, t0, 1'b0, 1'b0);
    scan_chk = 1'b1;
    n = 0;
    while (scan_chk && n < 40) begin
      tick();
      n++;
    end
    chk("scan_walk_done", int'(scan_chk), 0);
  endtask

  int base;

  initial begin
    rst = 1'b1; cf_pulse = 1'b0; sign = 1'b0;
    th = 4'd0; hu = 4'd0; te = 4'd0; on = 4'd9;
    repeat (3) tick();
    chk("rst_rd_req", int'(sif.rd_req), 0);
    chk("rst_tc",     int'(tc), 0);
    chk("rst_c_f",    int'(c_f), 0);
    chk("rst_upd",    int'(upd), 0);
    chk("rst_err",    int'(err), 0);
    chk("rst_an",     int'(an), 5'b11110);
    chk("rst_digit",  int'(digit), 9);
    chk("rst_blank",  int'(seg_blank), 0);
    chk("rst_minus",  int'(seg_minus), 0);

    // Positive burst: (400+401+402+404)/4 = 401.75 -> 401
    rd_q = '{400, 401, 402, 404};
    exp_q.push_back(401);
    base = req_cnt;
    rst  = 1'b0;
    wait_tc(1);
    chk("burst_req_pulses", req_at_upd - base, 4);
    tick();
    tick();
    chk("single_upd", upd_cnt, 1);

    // Negative burst with C/F toggles during WAIT: -5 >>> 2 = -2
    do_reset();
    rd_q = '{-1, -1, -1, -2};
    exp_q.push_back(-2);
    rst = 1'b0;
    wait_req("cf_req1");
    tick(); cf_pulse = 1'b1;
    tick(); cf_pulse = 1'b0;
    chk("cf_toggle1", int'(c_f), 1);
    wait_req("cf_req2");
    tick(); cf_pulse = 1'b1;
    tick(); cf_pulse = 1'b0;
    chk("cf_toggle2", int'(c_f), 0);
    wait_tc(2);

    // Next burst gets no ack: err appears 16 cycles after rd_req.
    wait_req("to_req");
    repeat (15) tick();
    chk("err_before_timeout", int'(err), 0);
    tick();
    chk("err_at_timeout", int'(err), 1);
    chk("tc_hold_on_timeout", int'(tc), -2);
    tick();
    tick();
`ifdef TEMP_DISP_ERR_EN
    chk("err_disp_minus", int'(seg_minus), 1);
    chk("err_disp_noblank", int'(seg_blank), 0);
`else
    chk("err_no_disp_effect", int'(seg_minus), 0);
`endif
    rst = 1'b1;
    tick();
    chk("err_cleared_by_rst", int'(err), 0);
    do_reset();

    // Scan walks, with zero-reading bursts keeping the sensor path healthy.
    rd_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(0);
    exp_q.push_back(0);
    rst = 1'b0;
    scan_walk(4'd0, 4'd0, 4'd7, 4'd5, 1'b0);
    scan_walk(4'd1, 4'd0, 4'd0, 4'd4, 1'b1);
    wait_tc(4);

    // Reset after two acks of a burst; next burst must average only fresh data.
    do_reset();
    rd_q = '{1000, 1000};
    base = ack_cnt;
    rst  = 1'b0;
    begin
      int n = 0;
      while (ack_cnt < base + 2 && n < 200) begin
        tick();
        n++;
      end
    end
    chk("mid_burst_acks", ack_cnt - base, 2);
    tick();
    tick();
    do_reset();
    rd_q = '{8, 12, 16, 20};
    exp_q.push_back(14);
    rst = 1'b0;
    wait_tc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temp_disp_ctl.md
Name: temp_disp_ctl

Overview:
- Sequencer that feeds the temperature display datapath: periodically requests readings from the temperature sensor interface, averages 2^AVG_LOG2 readings, and presents a stable tc / c_f pair to the display converter.
- Time-multiplexes the converter's BCD/sign outputs onto a 5-position seven-segment scan: one sign position and four digit positions, with leading-zero blanking.
- Sits between the sensor reader and the board-level seven-segment driver.

Parameters:
SAMPLE_CYCLES, 1_000_000, clock cycles between sample-burst starts
AVG_LOG2, 2, log2 of number of readings averaged (0..4)
TIMEOUT_CYCLES, 1023, max cycles waiting for rd_ack before abort
SCAN_CYCLES, 100_000, clock cycles each display position is lit

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rd_req  out  1  sensor read request
rd_ack  in  1  sensor read complete, one-cycle pulse
rd_data  in  13  signed reading, 0.0625 °C/LSB, valid with rd_ack
cf_pulse  in  1  debounced one-cycle pulse; toggles C/F
tc  out  13  signed averaged reading to converter
c_f  out  1  0 = Celsius, 1 = Fahrenheit
upd  out  1  one-cycle pulse when tc changes
err  out  1  sticky sensor-timeout flag
thousands, hundreds, tens, ones  in  4 each  BCD from converter
sign  in  1  converter sign, 1 = negative
an  out  5  active-low position enable; an[4] = sign position, an[0] = ones
digit  out  4  BCD value for the lit position
seg_blank  out  1  lit position shows nothing
seg_minus  out  1  lit position shows '-'

Behaviour:
- Reset values: rd_req=0, tc=0, c_f=0, upd=0, err=0, an=5'b11110, digit=ones, seg_blank=0, seg_minus=0. The sample counter, scan counter, accumulator and reading count all clear. rst wins over every other event, including mid-burst; any pending ack is discarded.
- Sample FSM states: IDLE, REQ, WAIT, ACC, UPDATE.
  - IDLE: advances to REQ when the sample counter reaches SAMPLE_CYCLES-1; the counter then wraps to 0 and free-runs through all states.
  - REQ: drives rd_req=1 for exactly one cycle, then goes to WAIT.
  - WAIT: rd_req=0; the timeout counter runs.
    - rd_ack → ACC.
    - Timeout counter reaches TIMEOUT_CYCLES → set err, clear accumulator and count, go to IDLE; tc unchanged.
    - rd_ack in the same cycle the timeout is reached counts as an ack.
  - ACC: sum += sign-extended rd_data (registered at ack), count++.
    - count == 2^AVG_LOG2 → UPDATE.
    - Otherwise → REQ; readings within a burst are back-to-back.
  - UPDATE: tc <= sum >>> AVG_LOG2 (arithmetic shift, floor toward −inf, low 13 bits); upd=1 this cycle; clear sum and count; go to IDLE.
- Accumulator width is 13+AVG_LOG2 signed bits, so it cannot overflow.
- A sample tick that occurs while not in IDLE is dropped, not queued.
- rd_ack outside WAIT is ignored.
- cf_pulse toggles c_f on the next edge in any state. tc is Celsius-domain and is not re-sampled on a toggle.
- err clears only on rst.
- Scan:
  - The position index cycles 0,1,2,3,4,0 (ones … sign), advancing every SCAN_CYCLES cycles.
  - an is a one-cold decode of the index.
  - digit is muxed from the BCD inputs; position 4 drives digit=0.
  - Leading-zero blanking: thousands blanked if 0; hundreds blanked if thousands and hundreds are both 0; tens is never blanked (tenths format d.d).
  - seg_minus=1 only at position 4 when sign=1; position 4 otherwise has seg_blank=1.
  - Scan outputs are registered and therefore lag the BCD inputs by one cycle.

Optional Feature:
- Macro: TEMP_DISP_ERR_EN.
- Defined: while err=1, every position has seg_blank=0 and seg_minus=1, so the display shows "-----". Sampling continues, but tc is still updated only by successful bursts.
- Undefined: err has no effect on the scan path; err is still driven.

Decomposition:
- Shared package temp_disp_pkg holds:
  - the sample-FSM state enum;
  - constants N_POS=5 and TC_W=13;
  - the scan position index typedef.
- One sub-module: disp_scan. It contains the scan counter, position decode, blanking and mux, and is reused by other display labs.
- The sample FSM and accumulator stay in the top.

Test Plan:
- Reset, then SAMPLE_CYCLES=8, AVG_LOG2=2; reply rd_ack 3 cycles after each rd_req with data 400, 401, 402, 404 → tc=401, single upd pulse, exactly 4 rd_req pulses.
- Readings −1, −1, −1, −2 → sum −5, tc=−2 (floor); sign path displays '-'.
- No rd_ack after a request, TIMEOUT_CYCLES=15 → err=1 sixteen cycles after rd_req, tc holds the previous value; rst clears err. With TEMP_DISP_ERR_EN defined, all positions show minus while err=1.
- cf_pulse pulses asserted during WAIT → c_f toggles on each pulse, and the burst still completes normally.
- BCD inputs 0,0,7,5 with sign=0, SCAN_CYCLES=2 → positions 3 and 2 blanked, 1 shows 7, 0 shows 5, position 4 blank; an walks 11110→11101→11011→10111→01111.
- rst asserted in the middle of a burst (after 2 acks) → after release, the next burst averages 4 fresh readings with no stale sum.
